// File: rtl/ent_sample_buffer_pkg.sv
// ent_sample_buffer_pkg
// Shared constants for the entropy sample buffer: register addresses,
// identification words, CTRL/STATUS bit positions and the capture FSM
// state encoding.
package ent_sample_buffer_pkg;

  localparam logic [7:0] ADDR_NAME0   = 8'h00;
  localparam logic [7:0] ADDR_NAME1   = 8'h01;
  localparam logic [7:0] ADDR_VERSION = 8'h02;
  localparam logic [7:0] ADDR_CTRL    = 8'h08;
  localparam logic [7:0] ADDR_STATUS  = 8'h09;
  localparam logic [7:0] ADDR_DATA    = 8'h0A;

  localparam logic [31:0] NAME0_VALUE = 32'h656e7473;  // "ents"
  localparam logic [31:0] NAME1_VALUE = 32'h62756666;  // "buff"

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_FLUSH_BIT       = 1;
  localparam int CTRL_SINGLE_SHOT_BIT = 2;

  localparam int STATUS_EMPTY_BIT    = 0;
  localparam int STATUS_FULL_BIT     = 1;
  localparam int STATUS_OVERFLOW_BIT = 2;
  localparam int STATUS_STATE_LSB    = 3;
  localparam int STATUS_COUNT_LSB    = 8;

  typedef enum logic [1:0] {
    CAP_IDLE    = 2'b00,
    CAP_CAPTURE = 2'b01,
    CAP_HALT    = 2'b10
  } cap_state_t;

endpackage

// File: rtl/ent_fifo.sv
// ent_fifo
// Synchronous FIFO of 32-bit words with combinational head output.
// Ports: clk, reset (sync, active-high), push/din, pop/dout (dout shows the
// oldest word), flush (clears pointers and count, wins over push/pop),
// full, empty, count (0..DEPTH).
module ent_fifo #(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [31:0]              din,
  output logic [31:0]              dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_COUNT = (AW+1)'(DEPTH);

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_COUNT);
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // When full, a push only fits because the same-cycle pop frees the slot.
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ent_sample_buffer.sv
// ent_sample_buffer
// Captures entropy sample words into a FIFO under control of a small capture
// FSM; software drains them through a register bus.
// Ports: clk, reset (sync, active-high); bus cs/we/address/write_data with
// combinational read_data/error; sample_valid/sample_data sample stream;
// debug = {overflow, full, count saturated at 63}.
//
// state   | meaning
// IDLE    | not capturing, samples ignored
// CAPTURE | samples pushed into the buffer
// HALT    | single-shot buffer filled, waiting for disable or flush
module ent_sample_buffer
  import ent_sample_buffer_pkg::*;
#(
  parameter int          DEPTH        = 32,
  parameter logic [31:0] CORE_VERSION = 32'h30_2e_31_30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cs,
  input  logic        we,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        error,
  input  logic        sample_valid,
  input  logic [31:0] sample_data,
  output logic [7:0]  debug
);

  localparam int CW = $clog2(DEPTH) + 1;

  cap_state_t      state;
  cap_state_t      state_next;
  logic            capture_active;
  logic            enable;
  logic            single_shot;
  logic            overflow;
  logic [CW-1:0]   count;
  logic [8:0]      count_ext;
  logic [5:0]      count_sat;
  logic            full;
  logic            empty;
  logic [31:0]     fifo_dout;
  logic            addr_mapped;
  logic            addr_ro;
  logic            ctrl_write;
  logic            flush;
  logic            pop;
  logic            push;
  logic [31:0]     status_word;
  logic            unused_write_data;

  assign unused_write_data = ^write_data[31:3];

  always_comb begin
    addr_mapped = 1'b1;
    addr_ro     = 1'b1;
    case (address)
      ADDR_NAME0, ADDR_NAME1, ADDR_VERSION, ADDR_STATUS, ADDR_DATA: ;
      ADDR_CTRL: addr_ro     = 1'b0;
      default:   addr_mapped = 1'b0;
    endcase
  end

  assign error = cs & (~addr_mapped | (we & addr_ro) |
                       (~we & (address == ADDR_DATA) & empty));

  assign ctrl_write = cs & we & (address == ADDR_CTRL);
  assign flush      = ctrl_write & write_data[CTRL_FLUSH_BIT];
  assign pop        = cs & ~we & (address == ADDR_DATA) & ~empty;
  // A sample arriving in the flush cycle is discarded.
  assign push       = capture_active & sample_valid & ~flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      enable      <= 1'b0;
      single_shot <= 1'b0;
    end else if (ctrl_write) begin
      enable      <= write_data[CTRL_ENABLE_BIT];
      single_shot <= write_data[CTRL_SINGLE_SHOT_BIT];
    end
  end

  // Overflow only records drops in free-running mode; single-shot fills
  // intentionally stop at full.
  always_ff @(posedge clk) begin
    if (reset || flush)
      overflow <= 1'b0;
    else if (push && full && !pop && !single_shot)
      overflow <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= CAP_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      CAP_IDLE:    if (enable) state_next = CAP_CAPTURE;
      CAP_CAPTURE: begin
        if (!enable)                 state_next = CAP_IDLE;
        else if (single_shot && full) state_next = CAP_HALT;
      end
      CAP_HALT:    if (!enable || flush) state_next = CAP_IDLE;
      default:     state_next = CAP_IDLE;
    endcase
  end

  always_comb begin
    capture_active = (state == CAP_CAPTURE);
  end

  ent_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (sample_data),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign count_ext = 9'(count);
  assign count_sat = (count_ext > 9'd63) ? 6'd63 : count_ext[5:0];
  assign debug     = {overflow, full, count_sat};

  always_comb begin
    status_word                               = '0;
    status_word[STATUS_EMPTY_BIT]             = empty;
    status_word[STATUS_FULL_BIT]              = full;
    status_word[STATUS_OVERFLOW_BIT]          = overflow;
    status_word[STATUS_STATE_LSB +: 2]        = state;
    status_word[STATUS_COUNT_LSB +: 9]        = count_ext;
  end

  always_comb begin
    read_data = '0;
    if (cs && !we && !error) begin
      case (address)
        ADDR_NAME0:   read_data = NAME0_VALUE;
        ADDR_NAME1:   read_data = NAME1_VALUE;
        ADDR_VERSION: read_data = CORE_VERSION;
        ADDR_CTRL: begin
          read_data[CTRL_ENABLE_BIT]      = enable;
          read_data[CTRL_SINGLE_SHOT_BIT] = single_shot;
        end
        ADDR_STATUS:  read_data = status_word;
        ADDR_DATA:    read_data = fifo_dout;
        default:      read_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_ent_sample_buffer.sv
module tb_ent_sample_buffer;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset;
  logic        cs;
  logic        we;
  logic [7:0]  address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        error;
  logic        sample_valid;
  logic [31:0] sample_data;
  logic [7:0]  debug;

  always #5 clk = ~clk;

  ent_sample_buffer #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .cs           (cs),
    .we           (we),
    .address      (address),
    .write_data   (write_data),
    .read_data    (read_data),
    .error        (error),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .debug        (debug)
  );

  int checks = 0;
  int errors = 0;

  // Behavioural model: a word queue plus a few flags.
  logic [31:0] m_q[$];
  bit          m_ovf = 0;
  bit          m_en  = 0;
  bit          m_ss  = 0;
  int          m_st  = 0;   // 0 idle, 1 capture, 2 halt
  bit          started = 0;
  bit          m_fl, m_pp, m_ps, m_was_full;
  int          m_nst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_status();
    logic [31:0] s;
    s = 32'(m_q.size()) << 8;
    s = s | (32'(m_st) << 3);
    if (m_ovf) s = s | 32'h4;
    if (m_q.size() == DEPTH) s = s | 32'h2;
    if (m_q.size() == 0) s = s | 32'h1;
    return s;
  endfunction

  function automatic logic exp_error();
    bit mapped, ro;
    if (!cs) return 1'b0;
    mapped = (address inside {8'h00, 8'h01, 8'h02, 8'h08, 8'h09, 8'h0A});
    ro     = (address != 8'h08);
    return !mapped || (we && ro) || (!we && address == 8'h0A && m_q.size() == 0);
  endfunction

  function automatic logic [31:0] exp_rdata();
    if (!cs || we || exp_error()) return 32'h0;
    case (address)
      8'h00:   return 32'h656e7473;
      8'h01:   return 32'h62756666;
      8'h02:   return 32'h302e3130;
      8'h08:   return {29'h0, m_ss, 1'b0, m_en};
      8'h09:   return exp_status();
      default: return m_q[0];
    endcase
  endfunction

  function automatic logic [7:0] exp_debug();
    int n;
    n = (m_q.size() > 63) ? 63 : m_q.size();
    return {m_ovf, (m_q.size() == DEPTH), 6'(n)};
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_q.delete();
      m_ovf = 0; m_en = 0; m_ss = 0; m_st = 0;
      started = 1;
    end else if (started) begin
      m_fl       = cs && we && address == 8'h08 && write_data[1];
      m_pp       = cs && !we && address == 8'h0A && m_q.size() > 0;
      m_ps       = (m_st == 1) && sample_valid;
      m_was_full = (m_q.size() == DEPTH);
      m_nst      = m_st;
      case (m_st)
        0: if (m_en) m_nst = 1;
        1: if (!m_en) m_nst = 0; else if (m_ss && m_was_full) m_nst = 2;
        default: if (!m_en || m_fl) m_nst = 0;
      endcase
      if (m_fl) begin
        m_q.delete();
        m_ovf = 0;
      end else begin
        if (m_pp) void'(m_q.pop_front());
        if (m_ps) begin
          if (!m_was_full || m_pp) m_q.push_back(sample_data);
          else if (!m_ss) m_ovf = 1;
        end
      end
      if (cs && we && address == 8'h08) begin
        m_en = write_data[0];
        m_ss = write_data[2];
      end
      m_st = m_nst;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("error", 32'(error), 32'(exp_error()));
      if (!(cs && we && !exp_error())) chk("read_data", read_data, exp_rdata());
      chk("debug", 32'(debug), 32'(exp_debug()));
    end
  end

  task automatic drive(input logic c, input logic w, input logic [7:0] a,
                       input logic [31:0] wd, input logic sv, input logic [31:0] sd,
                       input logic rst);
    @(posedge clk);
    #1;
    reset = rst; cs = c; we = w; address = a; write_data = wd;
    sample_valid = sv; sample_data = sd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 8'h00, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    drive(1, 1, a, d, 0, 32'h0, 0);
  endtask

  task automatic rd(input logic [7:0] a);
    drive(1, 0, a, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic smp(input logic [31:0] d);
    drive(0, 0, 8'h00, 32'h0, 1, d, 0);
  endtask

  task automatic lit_read(input string name, input logic [7:0] a, input logic [31:0] exp);
    rd(a);
    @(negedge clk);
    chk(name, read_data, exp);
  endtask

  task automatic lit_err(input string name, input logic w, input logic [7:0] a);
    drive(1, w, a, 32'h0, 0, 32'h0, 0);
    @(negedge clk);
    chk(name, 32'(error), 32'h1);
    chk({name, "_rdata"}, read_data, 32'h0);
  endtask

  initial begin
    reset = 1; cs = 0; we = 0; address = 0; write_data = 0;
    sample_valid = 0; sample_data = 0;
    repeat (2) @(posedge clk);
    idle(1);
    @(negedge clk);
    chk("reset_debug", 32'(debug), 32'h00);

    lit_read("name0", 8'h00, 32'h656e7473);
    lit_read("name1", 8'h01, 32'h62756666);
    lit_read("status_reset", 8'h09, 32'h00000001);
    chk("status_reset_err", 32'(error), 32'h0);
    lit_read("version", 8'h02, 32'h302e3130);

    // Three samples then drain.
    wr(8'h08, 32'h1);
    idle(2);
    smp(32'hA1); smp(32'hA2); smp(32'hA3);
    lit_read("data0", 8'h0A, 32'hA1);
    lit_read("data1", 8'h0A, 32'hA2);
    lit_read("data2", 8'h0A, 32'hA3);
    lit_err("data_empty", 0, 8'h0A);
    lit_read("status_empty", 8'h09, 32'h00000009);

    // Free-running overflow.
    wr(8'h08, 32'h3);
    for (int i = 0; i < 34; i++) smp(32'h100 + 32'(i));
    lit_read("status_ovf", 8'h09, 32'h0000200E);
    lit_read("data_ovf_first", 8'h0A, 32'h100);

    // Full buffer, simultaneous push and pop.
    wr(8'h08, 32'h3);
    for (int i = 0; i < 32; i++) smp(32'h200 + 32'(i));
    lit_read("status_full", 8'h09, 32'h0000200A);
    drive(1, 0, 8'h0A, 32'h0, 1, 32'h300, 0);
    @(negedge clk);
    chk("pushpop_data", read_data, 32'h200);
    lit_read("status_pushpop", 8'h09, 32'h0000200A);
    for (int i = 0; i < 31; i++) rd(8'h0A);
    lit_read("data_last", 8'h0A, 32'h300);
    lit_read("status_drained", 8'h09, 32'h00000009);

    // Single-shot halts at full.
    wr(8'h08, 32'h7);
    for (int i = 0; i < 40; i++) smp(32'h400 + 32'(i));
    lit_read("status_halt", 8'h09, 32'h00002012);
    lit_read("ctrl_halt", 8'h08, 32'h00000005);
    wr(8'h08, 32'h2);
    lit_read("status_flushed", 8'h09, 32'h00000001);

    // Illegal accesses.
    lit_err("wr_status", 1, 8'h09);
    lit_err("rd_unmapped", 0, 8'h55);
    lit_err("wr_name0", 1, 8'h00);

    // Reset mid-capture overrides a same-cycle CTRL write.
    wr(8'h08, 32'h1);
    idle(2);
    for (int i = 0; i < 10; i++) smp(32'h500 + 32'(i));
    lit_read("status_ten", 8'h09, 32'h00000A08);
    drive(1, 1, 8'h08, 32'h5, 1, 32'h5FF, 1);
    idle(1);
    @(negedge clk);
    chk("debug_after_reset", 32'(debug), 32'h00);
    lit_read("status_after_reset", 8'h09, 32'h00000001);
    lit_read("ctrl_after_reset", 8'h08, 32'h00000000);

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ent_sample_buffer.md
ENT_SAMPLE_BUFFER -- requirements
Module: ent_sample_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, number of 32-bit sample words buffered (power of two, 4..256).
REQ-002 SHALL have parameter CORE_VERSION, default 32'h30_2e_31_30, value returned at VERSION register.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port cs  input  1  bus access strobe from coretest initiator, one cycle per access.
REQ-006 SHALL have port we  input  1  1 = write, 0 = read, qualified by cs.
REQ-007 SHALL have port address  input  8  word register address.
REQ-008 SHALL have port write_data  input  32  write payload.
REQ-009 SHALL have port read_data  output  32  combinational read result, valid in the cs cycle.
REQ-010 SHALL have port error  output  1  combinational, high in the cs cycle for an illegal access.
REQ-011 SHALL have port sample_valid  input  1  entropy sample strobe.
REQ-012 SHALL have port sample_data  input  32  entropy sample word, qualified by sample_valid.
REQ-013 SHALL have port debug  output  8  {overflow, full, count[5:0]}, count saturating at 63.

Function
REQ-014 Register map SHALL be: 0x00 NAME0 = "ents" (RO), 0x01 NAME1 = "buff" (RO), 0x02 VERSION (RO), 0x08 CTRL (RW), 0x09 STATUS (RO), 0x0A DATA (RO, pop).
REQ-015 CTRL SHALL be: bit0 enable, bit1 flush (write-1 pulse, reads 0), bit2 single_shot; other bits read 0.
REQ-016 STATUS SHALL be: bit0 empty, bit1 full, bit2 overflow (sticky), bits[4:3] capture state, bits[16:8] count; other bits 0.
REQ-017 error SHALL be 1 for cs to an unmapped address, cs&we to any RO register, or cs&!we to DATA while empty; read_data SHALL be 0 whenever error is 1 or cs is 0.
REQ-018 Read of DATA when non-empty SHALL return the oldest word combinationally and pop it at the end of that cycle.
REQ-019 Capture FSM SHALL have states IDLE (00), CAPTURE (01), HALT (10).
REQ-020 IDLE -> CAPTURE when enable=1; CAPTURE -> IDLE when enable=0; CAPTURE -> HALT when single_shot=1 and buffer becomes full; HALT -> IDLE when enable=0 or flush.
REQ-021 Samples SHALL be pushed only in CAPTURE with sample_valid=1; push latency one cycle (count and empty update next cycle).
REQ-022 Push while full without simultaneous pop SHALL drop the sample and set overflow (CAPTURE, single_shot=0 only).
REQ-023 Simultaneous push and pop SHALL both take effect; count unchanged, including when full.
REQ-024 Flush SHALL clear pointers, count and overflow in the cycle after the write; a push in the flush cycle SHALL be discarded.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH; count SHALL range 0..DEPTH.
REQ-026 CTRL write SHALL update enable/single_shot the next cycle; FSM evaluates new values from that cycle.

Reset
REQ-027 On reset SHALL set: enable=0, single_shot=0, state IDLE, pointers 0, count 0, overflow 0.
REQ-028 Post-reset outputs SHALL be read_data=0, error=0, debug=8'h00; buffer RAM contents need not be cleared.
REQ-029 Reset asserted mid-capture SHALL discard all buffered samples and override any same-cycle bus write.

Structure
REQ-030 Package ent_sample_buffer_pkg SHALL hold register address constants, NAME0/NAME1 values, CTRL/STATUS bit indices and the FSM state encoding.
REQ-031 Storage SHALL be one sub-module ent_fifo (synchronous FIFO: push, pop, flush, full, empty, count, dout); bus decode and FSM stay in the top.

Verification
REQ-032 Reset, read 0x00/0x01/0x09 -> 32'h656e7473, 32'h62756666, STATUS=32'h00000001, error=0.
REQ-033 Enable, push 3 samples 0xA1,0xA2,0xA3, read DATA x3 -> 0xA1,0xA2,0xA3, then 4th read -> error=1, read_data=0, STATUS empty=1.
REQ-034 DEPTH=32, single_shot=0, push 34 samples without reads -> STATUS full=1, overflow=1, count=32, first DATA read = sample 0.
REQ-035 single_shot=1, push 40 samples -> state HALT (STATUS[4:3]=2'b10), count=32, overflow=0; write flush -> count 0, state IDLE.
REQ-036 Buffer full, simultaneous sample_valid and DATA read -> count stays 32, overflow stays 0, oldest word returned.
REQ-037 Write to 0x09 and access 0x55 -> error=1 each; assert reset mid-capture with 10 words -> next cycle count=0, state IDLE.
